fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 143 ++++++++++++++
 tb/tb_fetch_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-word prefetch queue.
// Issues sequential word fetches, collects in-order responses into a circular
// buffer and presents the oldest MAX_WORDS words as a command to the consumer.
// A redirect flushes the buffer and turns requests still in flight into
// "drop" credits, so their late responses are discarded rather than queued.
module fetch_queue #(
  parameter int              ADDR_W    = 32,
  parameter int              WORD_W    = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_WORDS = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        mem_req_valid,
  output logic [ADDR_W-1:0]           mem_req_addr,
  input  logic                        mem_req_ready,
  input  logic                        mem_rsp_valid,
  input  logic [WORD_W-1:0]           mem_rsp_data,
  output logic                        cmd_valid,
  output logic [MAX_WORDS*WORD_W-1:0] cmd_info,
  output logic [ADDR_W-1:0]           pc,
  input  logic                        consume,
  input  logic [1:0]                  consume_size,
  input  logic                        redirect,
  input  logic [ADDR_W-1:0]           redirect_off
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;
  localparam logic [PTR_W-1:0]  PTR_MASK = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(WORD_W / 8);

  logic [ADDR_W-1:0] fetch_addr_reg, fetch_addr_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [CNT_W-1:0]  pend_reg, pend_next;
  logic [CNT_W-1:0]  drop_reg, drop_next;
  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;

  logic [WORD_W-1:0] mem_array [DEPTH];

  logic [SUM_W-1:0] occupancy;
  logic             req_fire;
  logic             rsp_accept;
  logic             rsp_drop;
  logic             rsp_live;
  logic             consume_ok;
  logic             write_en;

  // Every word slot is either queued, requested live, or requested stale.
  assign occupancy     = SUM_W'(count_reg) + SUM_W'(pend_reg) + SUM_W'(drop_reg);
  assign mem_req_valid = rst_n && !redirect && (occupancy < SUM_W'(DEPTH));
  assign mem_req_addr  = fetch_addr_reg;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_accept = mem_rsp_valid && ((pend_reg != '0) || (drop_reg != '0));
  assign rsp_drop   = rsp_accept && (drop_reg != '0);
  assign rsp_live   = rsp_accept && (drop_reg == '0);
  assign write_en   = rsp_live && !redirect;

  assign cmd_valid  = rst_n && (count_reg >= CNT_W'(MAX_WORDS));
  assign consume_ok = consume && cmd_valid && !redirect && (consume_size != 2'd0) &&
                      (int'(consume_size) <= MAX_WORDS);
  assign pc         = pc_reg;

  // Oldest MAX_WORDS words, read straight out of the buffer from the head.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_WORDS; gi++) begin : g_word
      logic [PTR_W-1:0] rd_idx;
      assign rd_idx = (head_reg + PTR_W'(gi)) & PTR_MASK;
      assign cmd_info[gi*WORD_W +: WORD_W] = mem_array[rd_idx];
    end
  endgenerate

  // Next-state: redirect wins over consume and same-cycle response.
  always_comb begin
    fetch_addr_next = fetch_addr_reg;
    pc_next         = pc_reg;
    count_next      = count_reg;
    pend_next       = pend_reg;
    drop_next       = drop_reg;
    head_next       = head_reg;
    tail_next       = tail_reg;
    if (redirect) begin
      pc_next         = pc_reg + redirect_off;
      fetch_addr_next = pc_reg + redirect_off;
      count_next      = '0;
      pend_next       = '0;
      drop_next       = drop_reg + pend_reg - CNT_W'(rsp_accept);
      head_next       = tail_reg;
    end else begin
      if (req_fire) begin
        fetch_addr_next = fetch_addr_reg + STEP;
      end
      pend_next = pend_reg + CNT_W'(req_fire) - CNT_W'(rsp_live);
      if (rsp_drop) begin
        drop_next = drop_reg - CNT_W'(1);
      end
      if (rsp_live) begin
        tail_next = (tail_reg + PTR_W'(1)) & PTR_MASK;
      end
      if (consume_ok) begin
        head_next = (head_reg + PTR_W'(consume_size)) & PTR_MASK;
        pc_next   = pc_reg + ADDR_W'(consume_size) * STEP;
      end
      count_next = count_reg + CNT_W'(rsp_live) - (consume_ok ? CNT_W'(consume_size) : '0);
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_reg <= RESET_PC;
      pc_reg         <= RESET_PC;
      count_reg      <= '0;
      pend_reg       <= '0;
      drop_reg       <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
    end else begin
      fetch_addr_reg <= fetch_addr_next;
      pc_reg         <= pc_next;
      count_reg      <= count_next;
      pend_reg       <= pend_next;
      drop_reg       <= drop_next;
      head_reg       <= head_next;
      tail_reg       <= tail_next;
    end
  end

  // Word storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_array[tail_reg] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios followed by randomized traffic, checked
// against a queue-based model (word queue + list of in-flight requests tagged
// live or stale). The memory returns data equal to the request address.
module tb_fetch_queue;

  localparam int AW    = 32;
  localparam int WW    = 32;
  localparam int DEPTH = 4;
  localparam int MW    = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mem_req_valid;
  logic [AW-1:0]  mem_req_addr;
  logic           mem_req_ready;
  logic           mem_rsp_valid;
  logic [WW-1:0]  mem_rsp_data;
  logic           cmd_valid;
  logic [MW*WW-1:0] cmd_info;
  logic [AW-1:0]  pc;
  logic           consume;
  logic [1:0]     consume_size;
  logic           redirect;
  logic [AW-1:0]  redirect_off;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .cmd_valid    (cmd_valid),
    .cmd_info     (cmd_info),
    .pc           (pc),
    .consume      (consume),
    .consume_size (consume_size),
    .redirect     (redirect),
    .redirect_off (redirect_off)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model
  logic [WW-1:0] m_q[$];   // queued words, oldest first
  bit            m_fl[$];  // in-flight requests, 1 = live, 0 = stale
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_fa;

  // Memory responder
  typedef struct {
    logic [AW-1:0] addr;
    longint        due;
  } mreq_t;
  mreq_t         mq[$];
  longint        edge_cnt = 0;
  longint        last_due = 0;
  int            lat = 1;
  bit            spurious_en = 1'b0;
  logic [AW-1:0] req_log[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_req_valid();
    return !redirect && ((m_q.size() + m_fl.size()) < DEPTH);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_fl.delete();
    m_pc = '0;
    m_fa = '0;
    mq.delete();
    last_due = edge_cnt;
  endtask

  task automatic compare_outputs();
    logic [MW*WW-1:0] e;
    check("req_valid", mem_req_valid, m_req_valid());
    if (m_req_valid()) check("req_addr", mem_req_addr, m_fa);
    check("cmd_valid", cmd_valid, m_q.size() >= MW);
    check("pc", pc, m_pc);
    if (m_q.size() >= MW) begin
      e = '0;
      for (int k = 0; k < MW; k++) e[k*WW +: WW] = m_q[k];
      check("cmd_info", cmd_info, e);
    end
  endtask

  // One clock cycle: compare, advance the model, clock, drive memory response.
  task automatic cycle();
    bit            fire_dut;
    bit            m_fire;
    bit            acc;
    bit            f;
    logic [AW-1:0] a_dut;
    longint        due;
    #1;
    compare_outputs();
    fire_dut = mem_req_valid && mem_req_ready;
    a_dut    = mem_req_addr;
    m_fire   = m_req_valid() && mem_req_ready;
    acc = consume && !redirect && (m_q.size() >= MW) &&
          (consume_size >= 2'd1) && (int'(consume_size) <= MW);
    if (acc) begin
      repeat (int'(consume_size)) void'(m_q.pop_front());
      m_pc = m_pc + AW'(consume_size) * 32'd4;
    end
    if (mem_rsp_valid && m_fl.size() > 0) begin
      f = m_fl.pop_front();
      if (f && !redirect) m_q.push_back(mem_rsp_data);
    end
    if (redirect) begin
      m_q.delete();
      foreach (m_fl[i]) m_fl[i] = 1'b0;
      m_pc = m_pc + redirect_off;
      m_fa = m_pc;
    end
    if (m_fire) begin
      m_fl.push_back(1'b1);
      m_fa = m_fa + 32'd4;
    end
    if (fire_dut) req_log.push_back(a_dut);
    @(posedge clk);
    edge_cnt++;
    if (fire_dut) begin
      due = edge_cnt + longint'(lat);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{a_dut, due});
    end
    #1;
    if (mq.size() > 0 && mq[0].due == edge_cnt + 1) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mq[0].addr;
      void'(mq.pop_front());
    end else if (spurious_en && mq.size() == 0 && m_fl.size() == 0 &&
                 $urandom_range(0, 7) == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  endtask

  // Short asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_pc", pc, 32'h0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    rst_n = 1'b1;
    model_clear();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [MW*WW-1:0] ci;
    rst_n         = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    consume       = 1'b0;
    consume_size  = 2'd0;
    redirect      = 1'b0;
    redirect_off  = '0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_valid", mem_req_valid, 1'b0);
    check("reset_cmd_valid", cmd_valid, 1'b0);
    check("reset_pc", pc, 32'h0);
    rst_n = 1'b1;
    model_clear();

    // Initial fill: 0x0,0x4,0x8,0xC then stall
    repeat (8) cycle();
    check("fill_req_count", req_log.size(), 4);
    for (int k = 0; k < 4; k++) check("fill_req_addr", req_log[k], 32'(k * 4));
    check("fill_req_valid", mem_req_valid, 1'b0);
    check("fill_cmd_valid", cmd_valid, 1'b1);
    check("fill_cmd_info", cmd_info, 96'h00000008_00000004_00000000);
    check("fill_pc", pc, 32'h0);
    req_log.delete();

    // Consume two words, then refill
    consume = 1'b1; consume_size = 2'd2;
    cycle();
    consume = 1'b0;
    check("c2_pc", pc, 32'h8);
    check("c2_cmd_valid", cmd_valid, 1'b0);
    cycle();
    cycle();
    check("refill_addr", req_log[0], 32'h10);
    check("refill_cmd_info", cmd_info, 96'h00000010_0000000C_00000008);

    // Full queue holds off requests
    cycle();
    repeat (10) begin
      cycle();
      check("full_hold", mem_req_valid, 1'b0);
    end

    // Zero-size consume is ignored
    consume = 1'b1; consume_size = 2'd0;
    cycle();
    consume = 1'b0;
    check("c0_pc", pc, 32'h8);
    check("c0_cmd_info", cmd_info, 96'h00000010_0000000C_00000008);

    // Mid-stream reset pulse restarts fetching at 0
    consume = 1'b1; consume_size = 2'd3;
    cycle();
    consume = 1'b0;
    cycle();
    check("pre_rst_pc", pc, 32'h14);
    reset_pulse();
    req_log.delete();
    repeat (8) cycle();
    check("restart_count", req_log.size(), 4);
    for (int k = 0; k < 4; k++) check("restart_addr", req_log[k], 32'(k * 4));

    // Redirect with two live requests in flight
    consume = 1'b1; consume_size = 2'd2;
    cycle();
    consume = 1'b0;
    lat = 3;
    check("rd_pre_pc", pc, 32'h8);
    cycle();
    cycle();
    check("rd_pend_stall", mem_req_valid, 1'b0);
    redirect = 1'b1; redirect_off = 32'h100;
    cycle();
    redirect = 1'b0; redirect_off = '0;
    lat = 1;
    req_log.delete();
    check("rd_pc", pc, 32'h108);
    for (int i = 0; i < 20 && m_q.size() != 1; i++) cycle();
    check("rd_one_word_reached", m_q.size(), 1);
    // Consume larger than what is queued is ignored
    consume = 1'b1; consume_size = 2'd2;
    cycle();
    consume = 1'b0;
    check("c2_cnt1_pc", pc, 32'h108);
    repeat (6) cycle();
    check("rd_first_req", req_log[0], 32'h108);
    check("rd_cmd_valid", cmd_valid, 1'b1);
    ci = cmd_info;
    check("rd_word0", ci[WW-1:0], 32'h108);

    // Randomized traffic
    spurious_en = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 599) == 0) begin
        redirect = 1'b0;
        consume  = 1'b0;
        reset_pulse();
      end
      mem_req_ready = ($urandom_range(0, 3) != 0);
      lat           = int'($urandom_range(1, 3));
      consume       = $urandom_range(0, 1) == 1;
      consume_size  = 2'($urandom_range(0, 3));
      redirect      = ($urandom_range(0, 31) == 0);
      redirect_off  = $urandom;
      cycle();
    end
    redirect = 1'b0;
    consume  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
